// File: rtl/arb_requester_if.sv
// Command, arbiter and status signals of one arb_requester agent.
// The slave side is the requester itself; the master side is the command source plus arbiter.
interface arb_requester_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             req;
    logic             gnt;
    logic             beat_en;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic             busy;

    modport master (
        output cmd_valid, cmd_len, gnt,
        input  cmd_ready, req, beat_en, done, err, err_code, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, gnt,
        output cmd_ready, req, beat_en, done, err, err_code, busy
    );
endinterface

// File: rtl/arb_requester.sv
// Client-side requester for a shared req/grant arbiter: takes a burst command, requests
// the resource, runs cmd_len beats while granted, then keeps req low for GAP cycles.
module arb_requester #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 1
) (
    input  logic           clk,
    input  logic           rst,
    arb_requester_if.slave bus
);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GAP} state_t;

    // A finished or aborted burst backs off, unless there is no gap to hold.
    localparam state_t S_AFTER = state_t'((GAP > 0) ? S_GAP : S_IDLE);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] beat_cnt, beat_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             req_q;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic [1:0]       code_q, code_nxt;
    logic             cmd_ready_w;

    assign cmd_ready_w = (state == S_IDLE) && !rst;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt = state;
        len_nxt   = len_q;
        beat_nxt  = beat_cnt;
        wait_nxt  = wait_cnt;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = 2'b00;

        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_w) begin
                    len_nxt   = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                    beat_nxt  = '0;
                    wait_nxt  = '0;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.gnt) begin
                    state_nxt = S_OWN;
                end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    state_nxt = S_AFTER;
                    gap_nxt   = '0;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'b01;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_OWN: begin
                // Losing grant means no beat this cycle, so it aborts even on the last beat.
                if (!bus.gnt) begin
                    state_nxt = S_AFTER;
                    gap_nxt   = '0;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'b10;
                end else if (beat_cnt == len_q - 1'b1) begin
                    state_nxt = S_AFTER;
                    gap_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            beat_cnt <= beat_nxt;
            wait_cnt <= wait_nxt;
            gap_cnt  <= gap_nxt;
            req_q    <= (state_nxt == S_REQ) || (state_nxt == S_OWN);
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            code_q   <= code_nxt;
        end
    end

    assign bus.cmd_ready = cmd_ready_w;
    assign bus.req       = req_q;
    assign bus.beat_en   = (state == S_OWN) && bus.gnt;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_arb_requester.sv
// Randomized bench: one requester under free-running grant patterns plus three requesters
// sharing a round-robin arbiter, all compared each cycle against a transaction-level model.
module tb_arb_requester;
    localparam int N_CYC = 3000;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main agent: short lengths so the all-ones length is reachable, short timeout.
    arb_requester_if #(.LEN_W(4)) m_bus ();
    arb_requester #(.LEN_W(4), .TIMEOUT(4), .GAP(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_bus.slave)
    );

    logic [2:0] ag_valid;
    logic [2:0] ag_gnt;
    logic [7:0] ag_len [3];
    wire  [2:0] ag_req, ag_beat, ag_done, ag_err, ag_rdy;

    for (genvar i = 0; i < 3; i++) begin : g_ag
        arb_requester_if #(.LEN_W(8)) a_bus ();
        arb_requester #(.LEN_W(8), .TIMEOUT(0), .GAP(0)) u_ag (
            .clk (clk),
            .rst (rst),
            .bus (a_bus.slave)
        );
        assign a_bus.cmd_valid = ag_valid[i];
        assign a_bus.cmd_len   = ag_len[i];
        assign a_bus.gnt       = ag_gnt[i];
        assign ag_req[i]       = a_bus.req;
        assign ag_beat[i]      = a_bus.beat_en;
        assign ag_done[i]      = a_bus.done;
        assign ag_err[i]       = a_bus.err;
        assign ag_rdy[i]       = a_bus.cmd_ready;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction view of one agent: remaining beats, remaining patience, remaining back-off.
    typedef struct {
        bit active;
        bit granted;
        int beats_left;
        int patience;
        int hold_left;
        bit done;
        bit err;
        int code;
    } mdl_t;

    mdl_t mdl [4];
    int   tmo_of [4] = '{4, 0, 0, 0};
    int   gap_of [4] = '{1, 0, 0, 0};

    function automatic bit m_free(input int s);
        return !mdl[s].active && mdl[s].hold_left == 0;
    endfunction

    task automatic m_clear(input int s);
        mdl[s] = '{active: 0, granted: 0, beats_left: 0, patience: 0, hold_left: 0,
                   done: 0, err: 0, code: 0};
    endtask

    task automatic m_stop(input int s, input bit ok, input int code);
        mdl[s].active    = 0;
        mdl[s].granted   = 0;
        mdl[s].hold_left = gap_of[s];
        mdl[s].done      = ok;
        mdl[s].err       = !ok;
        mdl[s].code      = code;
    endtask

    task automatic m_advance(input int s, input bit r, input bit v, input int len, input bit g);
        mdl[s].done = 0;
        mdl[s].err  = 0;
        mdl[s].code = 0;
        if (r) begin
            m_clear(s);
        end else if (m_free(s)) begin
            if (v) begin
                mdl[s].active     = 1;
                mdl[s].granted    = 0;
                mdl[s].beats_left = (len == 0) ? 1 : len;
                mdl[s].patience   = tmo_of[s];
            end
        end else if (!mdl[s].active) begin
            mdl[s].hold_left--;
        end else if (!mdl[s].granted) begin
            if (g) begin
                mdl[s].granted = 1;
            end else if (tmo_of[s] != 0) begin
                mdl[s].patience--;
                if (mdl[s].patience == 0) m_stop(s, 0, 1);
            end
        end else begin
            if (!g) begin
                m_stop(s, 0, 2);
            end else begin
                mdl[s].beats_left--;
                if (mdl[s].beats_left == 0) m_stop(s, 1, 0);
            end
        end
    endtask

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 0;
        if (r == 1) return 15;
        if (r == 2) return 1;
        return $urandom_range(2, 6);
    endfunction

    int gnt_mode  = 0;
    int owner     = -1;
    int ag_dones [3] = '{0, 0, 0};
    int ag_errs  [3] = '{0, 0, 0};

    initial begin
        rst             = 1'b1;
        m_bus.cmd_valid = 1'b0;
        m_bus.cmd_len   = '0;
        m_bus.gnt       = 1'b0;
        ag_valid        = '0;
        ag_gnt          = '0;
        for (int i = 0; i < 3; i++) ag_len[i] = '0;
        for (int s = 0; s < 4; s++) m_clear(s);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            check("m_req",  m_bus.req,      mdl[0].active);
            check("m_done", m_bus.done,     mdl[0].done);
            check("m_err",  m_bus.err,      mdl[0].err);
            check("m_code", m_bus.err_code, mdl[0].code);
            check("m_busy", m_bus.busy,     !m_free(0));
            for (int i = 0; i < 3; i++) begin
                check($sformatf("a%0d_req", i),  ag_req[i],  mdl[i+1].active);
                check($sformatf("a%0d_done", i), ag_done[i], mdl[i+1].done);
                check($sformatf("a%0d_err", i),  ag_err[i],  mdl[i+1].err);
                ag_dones[i] += int'(ag_done[i]);
                ag_errs[i]  += int'(ag_err[i]);
            end

            rst = (cyc < 2) || ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 24) == 0) gnt_mode = $urandom_range(0, 3);
            m_bus.cmd_valid = ($urandom_range(0, 3) != 0);
            m_bus.cmd_len   = 4'(pick_len());
            case (gnt_mode)
                0:       m_bus.gnt = ($urandom_range(0, 19) != 0);
                1:       m_bus.gnt = 1'b0;
                2:       m_bus.gnt = $urandom_range(0, 1) != 0;
                default: m_bus.gnt = 1'b1;
            endcase

            // Round-robin arbiter: grant is held while the owner keeps req high.
            if (owner < 0 || !ag_req[owner]) begin
                int start;
                start = (owner < 0) ? 0 : owner + 1;
                owner = -1;
                for (int k = 0; k < 3; k++) begin
                    if (owner < 0 && ag_req[(start + k) % 3]) owner = (start + k) % 3;
                end
            end
            ag_gnt   = (owner < 0) ? 3'b000 : 3'(1 << owner);
            ag_valid = 3'b111;
            for (int i = 0; i < 3; i++) ag_len[i] = 8'($urandom_range(0, 2));

            #1;
            check("m_ready", m_bus.cmd_ready, m_free(0) && !rst);
            check("m_beat",  m_bus.beat_en,   mdl[0].active && mdl[0].granted && m_bus.gnt);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("a%0d_ready", i), ag_rdy[i], m_free(i+1) && !rst);
                check($sformatf("a%0d_beat", i),  ag_beat[i],
                      mdl[i+1].active && mdl[i+1].granted && ag_gnt[i]);
            end

            m_advance(0, rst, m_bus.cmd_valid, int'(m_bus.cmd_len), m_bus.gnt);
            for (int i = 0; i < 3; i++) m_advance(i + 1, rst, ag_valid[i], int'(ag_len[i]), ag_gnt[i]);
        end

        // Shared-arbiter agents must all make progress and never abort.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("a%0d_progress", i), ag_dones[i] > 0, 1);
            check($sformatf("a%0d_no_err", i),   ag_errs[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
